// File: rtl/sd_clk_pkg.sv
// Shared types and defaults for the SD clock-path sequencer.
package sd_clk_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        INIT,
        STABLE,
        WAIT_IDLE,
        GATE,
        SWITCH,
        SETTLE
    } state_e;

    localparam logic CLK_SLOW = 1'b0;
    localparam logic CLK_FAST = 1'b1;

    localparam int unsigned DEF_LOCK_WAIT     = 64;
    localparam int unsigned DEF_INIT_WAIT     = 16384;
    localparam int unsigned DEF_GATE_CYCLES   = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int          DEF_CNT_W         = 16;
    localparam int unsigned DEF_TIMEOUT       = 65535;

    // A state loaded with n stays n cycles: the counter runs n-1 .. 0, and 0 means 1 cycle.
    function automatic int unsigned wait_load(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal, async active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sd_clk_ctrl.sv
// SD clock-path sequencer: lock wait, init clocking, gated slow<->fast switching.
// Optional idle-wait timeout enabled by defining SD_CLK_TIMEOUT_EN.
module sd_clk_ctrl
    import sd_clk_pkg::*;
#(
    parameter int unsigned LOCK_WAIT     = DEF_LOCK_WAIT,
    parameter int unsigned INIT_WAIT     = DEF_INIT_WAIT,
    parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int          CNT_W         = DEF_CNT_W,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic ilock,
    input  logic ireq_fast,
    input  logic ibus_idle,
    output logic osel_clk,
    output logic oclk_en,
    output logic oready,
    output logic ofast,
    output logic oswitch_ack,
    output logic oerr
);

    localparam logic [CNT_W-1:0] LD_LOCK   = CNT_W'(wait_load(LOCK_WAIT));
    localparam logic [CNT_W-1:0] LD_INIT   = CNT_W'(wait_load(INIT_WAIT));
    localparam logic [CNT_W-1:0] LD_GATE   = CNT_W'(wait_load(GATE_CYCLES));
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(wait_load(SETTLE_CYCLES));

    // TIMEOUT is part of the width check in every build so a parameter set stays portable.
    localparam int unsigned MAX_WAIT = max2(max2(LOCK_WAIT, INIT_WAIT),
                                            max2(max2(GATE_CYCLES, SETTLE_CYCLES), TIMEOUT));

    if (CNT_W < 1 || longint'(MAX_WAIT) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("sd_clk_ctrl: CNT_W too narrow for the configured wait values");
    end

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (iclk),
        .rst_n (irst_n),
        .d     (ilock),
        .q     (lock_s)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sel_d, sel_q;
    logic             en_d, en_q;
    logic             rdy_d, rdy_q;
    logic             fast_d, fast_q;
    logic             ack_d, ack_q;
    logic             tgt_d, tgt_q;
    logic             cnt_zero;
    logic             switch_done;

`ifdef SD_CLK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(wait_load(TIMEOUT));
    logic err_d, err_q;
    // After a timeout, the host must drop the request before a new switch is tried.
    logic blk_d, blk_q;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        tgt_d   = tgt_q;
`ifdef SD_CLK_TIMEOUT_EN
        err_d   = err_q;
        blk_d   = blk_q;
`endif
        if (!lock_s && state_q != WAIT_LOCK) begin
            state_d = WAIT_LOCK;
            cnt_d   = LD_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = LD_LOCK;
                    end else if (cnt_zero) begin
                        state_d = INIT;
                        cnt_d   = LD_INIT;
                    end
                end
                INIT: begin
                    if (cnt_zero) state_d = STABLE;
                end
                STABLE: begin
`ifdef SD_CLK_TIMEOUT_EN
                    if (ireq_fast == fast_q) begin
                        blk_d = 1'b0;
                    end else if (!blk_q) begin
                        state_d = WAIT_IDLE;
                        tgt_d   = ireq_fast ? CLK_FAST : CLK_SLOW;
                        cnt_d   = LD_TIMEOUT;
                    end
`else
                    if (ireq_fast != fast_q) begin
                        state_d = WAIT_IDLE;
                        tgt_d   = ireq_fast ? CLK_FAST : CLK_SLOW;
                    end
`endif
                end
                WAIT_IDLE: begin
                    if (ireq_fast == fast_q) begin
                        state_d = STABLE;
                    end else if (ibus_idle) begin
                        state_d = GATE;
                        cnt_d   = LD_GATE;
                    end
`ifdef SD_CLK_TIMEOUT_EN
                    else if (cnt_zero) begin
                        state_d = STABLE;
                        err_d   = 1'b1;
                        blk_d   = 1'b1;
                    end
`endif
                end
                GATE: begin
                    if (cnt_zero) state_d = SWITCH;
                end
                SWITCH: begin
                    state_d = SETTLE;
                    cnt_d   = LD_SETTLE;
                end
                SETTLE: begin
                    if (cnt_zero) state_d = STABLE;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LD_LOCK;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign switch_done = (state_q == SETTLE) && (state_d == STABLE);

    always_comb begin
        en_d  = (state_d == INIT) || (state_d == STABLE) || (state_d == WAIT_IDLE);
        rdy_d = (state_d == STABLE);
        ack_d = switch_done;
        case (state_d)
            WAIT_LOCK, INIT: sel_d = CLK_SLOW;
            SWITCH:          sel_d = tgt_q;
            default:         sel_d = sel_q;
        endcase
        if (state_d == WAIT_LOCK || state_d == INIT) begin
            fast_d = CLK_SLOW;
        end else if (switch_done) begin
            fast_d = sel_q;
        end else begin
            fast_d = fast_q;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            sel_q   <= CLK_SLOW;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            fast_q  <= CLK_SLOW;
            ack_q   <= 1'b0;
            tgt_q   <= CLK_SLOW;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            fast_q  <= fast_d;
            ack_q   <= ack_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef SD_CLK_TIMEOUT_EN
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            err_q <= 1'b0;
            blk_q <= 1'b0;
        end else begin
            err_q <= err_d;
            blk_q <= blk_d;
        end
    end

    assign oerr = err_q;
`else
    assign oerr = 1'b0;
`endif

    assign osel_clk    = sel_q;
    assign oclk_en     = en_q;
    assign oready      = rdy_q;
    assign ofast       = fast_q;
    assign oswitch_ack = ack_q;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Scoreboard bench for sd_clk_ctrl: directed scenarios push expected output events,
// a negedge monitor pops and compares each event the DUT produces.
module tb_sd_clk_ctrl;

    localparam logic [3:0] F_RDY = 4'b0001;
    localparam logic [3:0] F_ACK = 4'b0010;
    localparam logic [3:0] F_EN  = 4'b0100;
    localparam logic [3:0] F_ERR = 4'b1000;

    typedef struct packed {
        int       cyc;
        logic [3:0] flags;
        logic     sel;
        logic     fast;
        logic     en;
        logic     rdy;
        logic     err;
    } ev_t;

    logic iclk, rst_n, ilock, ireq_fast, ibus_idle;
    logic osel_clk, oclk_en, oready, ofast, oswitch_ack, oerr;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    ev_t  mon_a, mon_e;
    logic p_rdy = 1'b0, p_en = 1'b0, p_err = 1'b0;

    sd_clk_ctrl #(.TIMEOUT(100)) dut (
        .iclk        (iclk),
        .irst_n      (rst_n),
        .ilock       (ilock),
        .ireq_fast   (ireq_fast),
        .ibus_idle   (ibus_idle),
        .osel_clk    (osel_clk),
        .oclk_en     (oclk_en),
        .oready      (oready),
        .ofast       (ofast),
        .oswitch_ack (oswitch_ack),
        .oerr        (oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // cyc = number of rising edges since reset release
    always @(posedge iclk) if (rst_n) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (rst_n) begin
            mon_a.cyc   = cyc;
            mon_a.flags = {oerr & ~p_err, oclk_en & ~p_en, oswitch_ack, oready & ~p_rdy};
            mon_a.sel   = osel_clk;
            mon_a.fast  = ofast;
            mon_a.en    = oclk_en;
            mon_a.rdy   = oready;
            mon_a.err   = oerr;
            if (mon_a.flags != 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d flags=%b sel=%b fast=%b en=%b rdy=%b err=%b",
                             mon_a.cyc, mon_a.flags, mon_a.sel, mon_a.fast, mon_a.en, mon_a.rdy, mon_a.err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_a != mon_e) begin
                        failures++;
                        $display("FAIL event actual cyc=%0d flags=%b sel=%b fast=%b en=%b rdy=%b err=%b required cyc=%0d flags=%b sel=%b fast=%b en=%b rdy=%b err=%b",
                                 mon_a.cyc, mon_a.flags, mon_a.sel, mon_a.fast, mon_a.en, mon_a.rdy, mon_a.err,
                                 mon_e.cyc, mon_e.flags, mon_e.sel, mon_e.fast, mon_e.en, mon_e.rdy, mon_e.err);
                    end
                end
            end
            p_rdy <= oready;
            p_en  <= oclk_en;
            p_err <= oerr;
        end
    end

    task automatic expect_ev(input int c, input logic [3:0] f, input logic sel, input logic fast,
                             input logic en, input logic rdy, input logic err);
        ev_t e;
        e.cyc = c; e.flags = f; e.sel = sel; e.fast = fast; e.en = en; e.rdy = rdy; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge iclk);
    endtask

    int c, c2, r;

    initial begin
        rst_n = 1'b1; ilock = 1'b0; ireq_fast = 1'b0; ibus_idle = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst_sel", osel_clk, 0);
        chk("rst_en", oclk_en, 0);
        chk("rst_rdy", oready, 0);
        chk("rst_fast", ofast, 0);
        chk("rst_ack", oswitch_ack, 0);
        chk("rst_err", oerr, 0);
        rst_n = 1'b1;

        // Lock at cycle 5: 2 sync edges + 64 lock cycles, then INIT_WAIT of slow clock.
        go_to(5);
        ilock = 1'b1;
        expect_ev(71, F_EN, 0, 0, 1, 0, 0);
        expect_ev(71 + 16384, F_RDY, 0, 0, 1, 1, 0);
        go_to(70);
        chk("lockwait_en", oclk_en, 0);
        go_to(100);
        chk("init_sel", osel_clk, 0);
        chk("init_rdy", oready, 0);
        go_to(16460);
        chk("stable_rdy", oready, 1);

        // Slow->fast, bus idle: STABLE registers request at c+1, ack 34 cycles later.
        c = cyc;
        ireq_fast = 1'b1;
        expect_ev(c + 35, F_RDY | F_ACK | F_EN, 1, 1, 1, 1, 0);
        go_to(c + 1);
        chk("req_rdy_drop", oready, 0);
        chk("wait_idle_en", oclk_en, 1);
        go_to(c + 2);
        chk("gate_en", oclk_en, 0);
        go_to(c + 17);
        chk("gate_end_sel", osel_clk, 0);
        go_to(c + 18);
        chk("switch_sel", osel_clk, 1);
        chk("switch_en", oclk_en, 0);
        go_to(c + 34);
        chk("settle_end_en", oclk_en, 0);
        go_to(c + 40);

        // Fast->slow, bus idle.
        c = cyc;
        ireq_fast = 1'b0;
        expect_ev(c + 35, F_RDY | F_ACK | F_EN, 0, 0, 1, 1, 0);
        go_to(c + 40);

        // Request withdrawn while the bus is busy: back to STABLE, no gating, no ack.
        ibus_idle = 1'b0;
        c = cyc;
        ireq_fast = 1'b1;
        expect_ev(c + 6, F_RDY, 0, 0, 1, 1, 0);
        go_to(c + 3);
        chk("withdraw_rdy", oready, 0);
        chk("withdraw_en", oclk_en, 1);
        go_to(c + 5);
        ireq_fast = 1'b0;
        go_to(c + 20);
        chk("withdraw_sel", osel_clk, 0);

        // Busy bus for 100 cycles, then idle: switch completes 33 cycles after idle.
        c = cyc;
        ireq_fast = 1'b1;
        go_to(c + 100);
        chk("busy_en", oclk_en, 1);
        chk("busy_sel", osel_clk, 0);
        chk("busy_rdy", oready, 0);
        ibus_idle = 1'b1;
        expect_ev(c + 134, F_RDY | F_ACK | F_EN, 1, 1, 1, 1, 0);
        go_to(c + 140);

        c = cyc;
        ireq_fast = 1'b0;
        expect_ev(c + 35, F_RDY | F_ACK | F_EN, 0, 0, 1, 1, 0);
        go_to(c + 40);

        // Lock lost during SETTLE of a fast switch.
        c = cyc;
        ireq_fast = 1'b1;
        go_to(c + 24);
        chk("settle_sel", osel_clk, 1);
        ilock = 1'b0;
        go_to(c + 26);
        chk("lockloss_pre_sel", osel_clk, 1);
        go_to(c + 27);
        chk("lockloss_sel", osel_clk, 0);
        chk("lockloss_en", oclk_en, 0);
        chk("lockloss_rdy", oready, 0);
        chk("lockloss_fast", ofast, 0);
        go_to(c + 30);
        ireq_fast = 1'b0;
        go_to(c + 40);
        r = cyc;
        ilock = 1'b1;
        expect_ev(r + 66, F_EN, 0, 0, 1, 0, 0);
        expect_ev(r + 66 + 16384, F_RDY, 0, 0, 1, 1, 0);
        go_to(r + 16460);

`ifdef SD_CLK_TIMEOUT_EN
        // Bus never idle: timeout after 100 WAIT_IDLE cycles, mode kept, switch blocked.
        ibus_idle = 1'b0;
        c = cyc;
        ireq_fast = 1'b1;
        expect_ev(c + 101, F_RDY | F_ERR, 0, 0, 1, 1, 1);
        go_to(c + 50);
        chk("to_err_early", oerr, 0);
        go_to(c + 120);
        chk("to_blocked_rdy", oready, 1);
        chk("to_fast", ofast, 0);
        c2 = cyc;
        ireq_fast = 1'b0;
        go_to(c2 + 2);
        ireq_fast = 1'b1;
        ibus_idle = 1'b1;
        expect_ev(c2 + 37, F_RDY | F_ACK | F_EN, 1, 1, 1, 1, 1);
        go_to(c2 + 45);
`else
        chk("err_tied", oerr, 0);
`endif

        go_to(cyc + 10);
        chk("events_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_clk_ctrl.md
Name: sd_clk_ctrl

Overview:
- Sequencer for the SD clock path (PLL, slow/fast dividers, DCS mux).
- Runs in the PLL reference-output domain.
- Waits for PLL lock, enforces the card-init clock period on the slow clock, then performs glitch-safe slow<->fast switches on host request:
  - only when the SD bus is idle;
  - SD clock gated around each switch.
- Drives the divider select and the SD clock enable; reports readiness to the SD host FSM.

Parameters:
LOCK_WAIT, 64, iclk cycles ilock must stay high before init starts
INIT_WAIT, 16384, iclk cycles of slow SD clock after lock (>=74 slow SD clocks at 400 kHz)
GATE_CYCLES, 16, iclk cycles clock held gated before select changes
SETTLE_CYCLES, 16, iclk cycles after select change before clock re-enabled
CNT_W, 16, shared wait-counter width; must hold max of all wait parameters
TIMEOUT, 65535, iclk cycles allowed waiting for ibus_idle (optional feature only)

Ports:
iclk  in  1  clock (PLL clkout domain)
irst_n  in  1  reset, asynchronous, active-low
ilock  in  1  PLL lock, synchronised internally (2-flop)
ireq_fast  in  1  level: 1 = host wants fast clock, 0 = slow
ibus_idle  in  1  1 = no command/data transfer in progress
osel_clk  out  1  divider select to clock mux: 0 slow, 1 fast
oclk_en  out  1  SD clock enable (gate after mux)
oready  out  1  clock stable, init done, no switch pending
ofast  out  1  current stable mode is fast
oswitch_ack  out  1  one-cycle pulse when a requested switch completes
oerr  out  1  sticky idle-wait timeout (tied 0 without feature)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: osel_clk=0, oclk_en=0, oready=0, ofast=0, oswitch_ack=0, oerr=0; state WAIT_LOCK; counter=0.
- Single down-counter, CNT_W bits, loaded on state entry; a state exits the cycle the counter reaches 0.
- States:
  - WAIT_LOCK: sel=0, en=0. Counter reloads LOCK_WAIT while synced lock=0. Lock high LOCK_WAIT consecutive cycles -> INIT.
  - INIT: sel=0, en=1. INIT_WAIT cycles -> STABLE.
  - STABLE: oready=1. ireq_fast != ofast -> WAIT_IDLE (oready drops the same cycle).
  - WAIT_IDLE: en=1, oready=0. ibus_idle=1 -> GATE.
  - GATE: en=0. GATE_CYCLES cycles -> SWITCH.
  - SWITCH: osel_clk <= target; one cycle -> SETTLE.
  - SETTLE: en=0. SETTLE_CYCLES cycles -> STABLE. On entry to STABLE: en=1, ofast=osel_clk, oswitch_ack pulses one cycle.
- Target latch: target = ireq_fast, latched on STABLE->WAIT_IDLE exit; later ireq_fast changes are ignored until STABLE.
  - Request withdrawn during WAIT_IDLE (ireq_fast == ofast): return to STABLE without gating; no ack.
  - Request reversed after GATE: the switch completes; STABLE re-evaluates and starts a new switch.
- Lock loss: synced ilock=0 in any state except WAIT_LOCK -> WAIT_LOCK in the next cycle.
  - osel_clk=0, oclk_en=0, ofast=0, oready=0.
  - Full INIT repeats; no ack.
- ibus_idle is sampled only in WAIT_IDLE; the bus going busy during GATE/SETTLE is a host protocol violation and is not handled.
- Parameter value 0 is treated as 1 cycle.
- Latency: request in STABLE to ack = 1 + idle wait + GATE_CYCLES + 1 + SETTLE_CYCLES cycles (minimum 34 with defaults).

Optional Feature:
SD_CLK_TIMEOUT_EN:
- Defined:
  - WAIT_IDLE runs a TIMEOUT counter. Expiry -> oerr=1 (sticky until reset), return to STABLE keeping the current mode, no ack.
  - A new switch is not started until ireq_fast toggles back to ofast and away again.
- Undefined: WAIT_IDLE waits indefinitely; oerr tied 0.

Decomposition:
- Package sd_clk_pkg:
  - state enum (WAIT_LOCK, INIT, STABLE, WAIT_IDLE, GATE, SWITCH, SETTLE);
  - CLK_SLOW=1'b0 / CLK_FAST=1'b1 constants;
  - default wait constants.
- Sub-module sync_2ff (2-flop synchroniser, async active-low reset) for ilock; reusable elsewhere.
- Counter and FSM stay in sd_clk_ctrl.

Test Plan:
- Reset, ilock=1 from cycle 5 -> oclk_en=1 at 5+2+64 (+/-1); oready=1 exactly INIT_WAIT cycles later; osel_clk=0 throughout.
- In STABLE, ireq_fast=1, ibus_idle=1 -> oclk_en low 16, osel_clk=1, low 16 more; then oclk_en=1, ofast=1, oswitch_ack single pulse 34 cycles after request.
- ireq_fast=1 with ibus_idle=0 for 100 cycles -> oclk_en stays 1, osel_clk=0; idle asserted -> switch completes 33 cycles later.
- ireq_fast pulsed 1 then back to 0 while bus busy -> no gating, no ack, oready returns 1.
- ilock dropped in SETTLE of a fast switch -> 3 cycles later osel_clk=0, oclk_en=0, oready=0; relock -> full INIT repeats.
- SD_CLK_TIMEOUT_EN with TIMEOUT=100, bus never idle -> oerr=1 after 100 cycles, state STABLE, ofast unchanged, no ack.
